// File: rtl/uart_rx.sv
// UART receiver: 8N1 deserialiser with a 2-FF synchroniser and mid-bit sampling.
// Define UART_RX_PARITY_EN to add one even-parity bit between data and stop.
module uart_rx #(
  parameter int unsigned bps = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_uart,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] BIT_END = 16'(bps - 1);
  localparam logic [15:0] BIT_MID = 16'(bps / 2 - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd5,
`endif
    BREAK  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        rx_s1;
  logic        rx_s2;
  logic        rx_s3;
  logic        line;
  logic        fall;

  logic [15:0] cnt0;
  logic [2:0]  cnt1;
  logic [7:0]  shreg;
  logic        mid;
  logic        bit_end;
  logic        run;
  logic        par_ok;
  logic        vld_nxt;
  logic        err_nxt;

  // rx_s3 holds the previous synchronised sample for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_uart;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign line    = rx_s2;
  assign fall    = rx_s3 & ~rx_s2;
  assign mid     = (cnt0 == BIT_MID);
  assign bit_end = (cnt0 == BIT_END);
  assign busy    = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit <= 1'b0;
    end else if (state == PARITY && mid) begin
      par_bit <= line;
    end
  end

  assign par_ok = ~^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fall) state_nxt = START;
      end
      START: begin
        if (mid && line) state_nxt = IDLE;
        else if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && cnt1 == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (mid) state_nxt = line ? IDLE : BREAK;
      end
      BREAK: begin
        if (line) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a bad stop or bad parity yields exactly one error strobe per frame
  always_comb begin
    run     = 1'b0;
    vld_nxt = 1'b0;
    err_nxt = 1'b0;
    case (state)
      START, DATA: run = 1'b1;
`ifdef UART_RX_PARITY_EN
      PARITY: run = 1'b1;
`endif
      STOP: begin
        run = 1'b1;
        if (mid) begin
          vld_nxt = line & par_ok;
          err_nxt = ~(line & par_ok);
        end
      end
      default: run = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
    end else if (!run || bit_end || state_nxt != state) begin
      cnt0 <= '0;
    end else begin
      cnt0 <= cnt0 + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0;
    end else if (state != DATA) begin
      cnt1 <= '0;
    end else if (bit_end) begin
      cnt1 <= cnt1 + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (state == DATA && mid) begin
      shreg[cnt1] <= line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      dout_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dout_vld  <= vld_nxt;
      frame_err <= err_nxt;
      if (vld_nxt) dout <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: vector table of frames plus
// back-to-back, glitch, mid-frame reset and parity sequences.
module tb_uart_rx;

  localparam int BPS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + 10 * BPS + BPS / 2;
`else
  localparam int LAT = 3 + 9 * BPS + BPS / 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_uart = 1'b1;
  logic [7:0] dout;
  logic       dout_vld;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.bps(BPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_uart   (rx_uart),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int cyc = 0;
  int vld_cyc = 0;
  int fall_cyc = 0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_vld) begin
      vld_cnt = vld_cnt + 1;
      vld_cyc = cyc;
      got_q.push_back(dout);
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (dout_vld && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_uart = b;
    wait_cyc(BPS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_uart = 1'b0;
    fall_cyc = cyc;
    wait_cyc(BPS);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_vld;
    int         exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vt[6];

  initial begin
    int v0;
    int e0;
    int lat;
    int busy_seen;
    int busy_clr;
    logic [7:0] b2b[3];

    vt[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vt[1] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    vt[2] = '{8'h55, 1'b0, 0, 1, 8'h3C};
    vt[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vt[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vt[5] = '{8'h81, 1'b1, 1, 0, 8'h81};
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h3C;

    wait_cyc(3);
    chk("rst_dout", int'(dout), 0);
    chk("rst_vld", int'(dout_vld), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    wait_cyc(10);

    for (int i = 0; i < 6; i++) begin
      v0 = vld_cnt;
      e0 = err_cnt;
      send_frame(vt[i].data, vt[i].stop);
      if (!vt[i].stop) begin
        wait_cyc(3 * BPS);
        rx_uart = 1'b1;
      end
      wait_cyc(4);
      chk($sformatf("vec%0d_vld", i), vld_cnt - v0, vt[i].exp_vld);
      chk($sformatf("vec%0d_err", i), err_cnt - e0, vt[i].exp_err);
      chk($sformatf("vec%0d_dout", i), int'(dout), int'(vt[i].exp_dout));
      chk($sformatf("vec%0d_busy", i), int'(busy), 0);
      if (vt[i].exp_vld == 1) begin
        lat = vld_cyc - fall_cyc;
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
          errors++;
          $display("FAIL vec%0d_lat: got %0d expected %0d", i, lat, LAT);
        end
      end
    end

    got_q.delete();
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b1);
    wait_cyc(4);
    chk("b2b_count", got_q.size(), 3);
    chk("b2b_err", err_cnt - e0, 0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("b2b_byte%0d", i),
          (got_q.size() > i) ? int'(got_q[i]) : -1, int'(b2b[i]));

    v0 = vld_cnt;
    e0 = err_cnt;
    busy_seen = 0;
    busy_clr = -1;
    rx_uart = 1'b0;
    for (int k = 1; k <= BPS / 2 + 10; k++) begin
      @(negedge clk);
      if (k == 20) rx_uart = 1'b1;
      if (busy) busy_seen = 1;
      else if (busy_seen == 1 && busy_clr < 0) busy_clr = k;
    end
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy_clr_ok",
        int'(busy_clr > 0 && busy_clr <= BPS / 2 + 3), 1);
    chk("glitch_vld", vld_cnt - v0, 0);
    chk("glitch_err", err_cnt - e0, 0);

    v0 = vld_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i < 2);
    rx_uart = 1'b0;
    wait_cyc(BPS / 2);
    rst_n = 1'b0;
    rx_uart = 1'b1;
    wait_cyc(5);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_dout", int'(dout), 0);
    rst_n = 1'b1;
    wait_cyc(10);
    chk("midrst_vld", vld_cnt - v0, 0);
    chk("midrst_err", err_cnt - e0, 0);
    send_frame(8'h81, 1'b1);
    wait_cyc(4);
    chk("after_rst_vld", vld_cnt - v0, 1);
    chk("after_rst_dout", int'(dout), 8'h81);

`ifdef UART_RX_PARITY_EN
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame_par(8'h07, 1'b1);
    wait_cyc(4);
    chk("par_good_vld", vld_cnt - v0, 1);
    chk("par_good_err", err_cnt - e0, 0);
    chk("par_good_dout", int'(dout), 8'h07);
    v0 = vld_cnt;
    e0 = err_cnt;
    send_frame_par(8'h07, 1'b0);
    wait_cyc(4);
    chk("par_bad_vld", vld_cnt - v0, 0);
    chk("par_bad_err", err_cnt - e0, 1);
    chk("par_bad_busy", int'(busy), 0);
`endif

    chk("vld_err_overlap", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
